buckeye_chain_loader: RTL and testbench



---
 rtl/bky_pkg.sv | 27 ++
 rtl/bky_sync_fifo.sv | 76 +++++++
 rtl/buckeye_chain_loader.sv | 167 ++++++++++++++++
 tb/tb_buckeye_chain_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bky_pkg.sv
// Shared state codes and helpers for the Buckeye chain loader.
package bky_pkg;

  localparam logic [2:0] StateIdle  = 3'd0;
  localparam logic [2:0] StateLoad  = 3'd1;
  localparam logic [2:0] StateShift = 3'd2;
  localparam logic [2:0] StateNext  = 3'd3;
  localparam logic [2:0] StateFin   = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = StateIdle,
    StLoad  = StateLoad,
    StShift = StateShift,
    StNext  = StateNext,
    StFin   = StateFin
  } bky_state_e;

  function automatic int unsigned bky_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bky_sync_fifo.sv
// Single-clock FIFO with registered flags, fill count and simultaneous push/pop.
module bky_sync_fifo import bky_pkg::*; #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 512
) (
  input  logic                        CLK40,
  input  logic                        RST_N,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [Width-1:0]            din_i,
  output logic [Width-1:0]            dout_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [bky_clog2(Depth):0]   fill_o
);

  localparam int unsigned AddrW = bky_clog2(Depth);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   fill_q, fill_d;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    fill_d = fill_q;
    if (flush_i) begin
      fill_d = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   fill_d = fill_q + (AddrW + 1)'(1);
        2'b01:   fill_d = fill_q - (AddrW + 1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge CLK40) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      fill_q  <= fill_d;
      empty_q <= (fill_d == '0);
      full_q  <= (fill_d == DepthCnt);
    end
  end

  always_ff @(posedge CLK40) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign fill_o  = fill_q;

endmodule

// File: rtl/buckeye_chain_loader.sv
// Buffers words and shifts them LSB-first into up to NCHAN Buckeye chains on a divided SCLK.
// Optional parity checking of buffered words is enabled by defining BKY_PARITY_EN.
module buckeye_chain_loader import bky_pkg::*; #(
  parameter int unsigned NCHAN    = 6,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned HALF_DIV = 20
) (
  input  logic                      CLK40,
  input  logic                      RST_N,
  input  logic                      CAPTURE,
  input  logic [WORD_W-1:0]         DIN,
  input  logic                      START,
  input  logic [NCHAN-1:0]          CHAN_MASK,
  input  logic                      FLUSH,
  input  logic                      CLR_DONE,
`ifdef BKY_PARITY_EN
  input  logic                      DIN_PAR,
  output logic                      PAR_ERR,
`endif
  output logic                      SCLK,
  output logic [NCHAN-1:0]          SDATA,
  output logic                      SHCK_ENA,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      OVF,
  output logic [bky_clog2(DEPTH):0] FILL,
  output logic [2:0]                STATE
);

  localparam int unsigned DivW = bky_clog2(2 * HALF_DIV);
  localparam int unsigned BitW = bky_clog2(WORD_W) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(2 * HALF_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(HALF_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(WORD_W - 1);
`ifdef BKY_PARITY_EN
  localparam int unsigned FifoW = WORD_W + 1;
`else
  localparam int unsigned FifoW = WORD_W;
`endif

  bky_state_e        state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [NCHAN-1:0]  mask_q, mask_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              fifo_pop, fifo_flush;
  logic [FifoW-1:0]  fifo_din, fifo_dout;

`ifdef BKY_PARITY_EN
  logic par_err_q, par_err_d;
  assign fifo_din = {DIN_PAR, DIN};
  assign PAR_ERR  = par_err_q;
`else
  assign fifo_din = DIN;
`endif

  assign fifo_flush = FLUSH && (state_q == StIdle);

  bky_sync_fifo #(
    .Width (FifoW),
    .Depth (DEPTH)
  ) u_fifo (
    .CLK40   (CLK40),
    .RST_N   (RST_N),
    .push_i  (CAPTURE),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .empty_o (EMPTY),
    .full_o  (FULL),
    .fill_o  (FILL)
  );

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    mask_d   = mask_q;
    div_d    = div_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START && !EMPTY) begin
          mask_d  = CHAN_MASK;
          state_d = StLoad;
        end
      end
      StLoad: begin
        fifo_pop = 1'b1;
        sreg_d   = fifo_dout[WORD_W-1:0];
        div_d    = '0;
        bit_d    = '0;
        state_d  = StShift;
      end
      StShift: begin
        // Divider wrap is the SCLK falling edge: advance to the next bit.
        if (div_q == DivLast) begin
          div_d  = '0;
          sreg_d = {1'b0, sreg_q[WORD_W-1:1]};
          bit_d  = bit_q + BitW'(1);
          if (bit_q == BitLast) state_d = StNext;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StNext:  state_d = EMPTY ? StFin : StLoad;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d = done_q;
    if (state_q == StFin) done_d = 1'b1;
    if (CLR_DONE)         done_d = 1'b0;
    ovf_d = ovf_q;
    if (CAPTURE && FULL && !fifo_pop) ovf_d = 1'b1;
    if (CLR_DONE)                     ovf_d = 1'b0;
`ifdef BKY_PARITY_EN
    par_err_d = par_err_q;
    if ((state_q == StLoad) && (^fifo_dout)) par_err_d = 1'b1;
    if (CLR_DONE)                            par_err_d = 1'b0;
`endif
  end

  always_ff @(posedge CLK40) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      mask_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef BKY_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      mask_q    <= mask_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
`ifdef BKY_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Line outputs decode registered state only, so they are quiet outside SHIFT.
  assign SHCK_ENA = (state_q == StShift);
  assign SCLK     = SHCK_ENA && (div_q >= DivHalf);
  assign SDATA    = SHCK_ENA ? ({NCHAN{sreg_q[0]}} & mask_q) : '0;
  assign BUSY     = (state_q != StIdle);
  assign DONE     = done_q;
  assign OVF      = ovf_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_buckeye_chain_loader.sv
// Randomised self-checking bench for buckeye_chain_loader against a queue-based line model.
// Parity checks are included when BKY_PARITY_EN is defined.
module tb_buckeye_chain_loader;

  localparam int unsigned NCHAN    = 6;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned HALF_DIV = 2;
  localparam int unsigned BIT_CYC  = 2 * HALF_DIV;

  logic              CLK40, RST_N, CAPTURE, START, FLUSH, CLR_DONE;
  logic [WORD_W-1:0] DIN;
  logic [NCHAN-1:0]  CHAN_MASK;
  logic              SCLK, SHCK_ENA, BUSY, DONE, EMPTY, FULL, OVF;
  logic [NCHAN-1:0]  SDATA;
  logic [3:0]        FILL;
  logic [2:0]        STATE;
`ifdef BKY_PARITY_EN
  logic              DIN_PAR, PAR_ERR;
`endif

  buckeye_chain_loader #(
    .NCHAN    (NCHAN),
    .WORD_W   (WORD_W),
    .DEPTH    (DEPTH),
    .HALF_DIV (HALF_DIV)
  ) dut (
    .CLK40     (CLK40),
    .RST_N     (RST_N),
    .CAPTURE   (CAPTURE),
    .DIN       (DIN),
    .START     (START),
    .CHAN_MASK (CHAN_MASK),
    .FLUSH     (FLUSH),
    .CLR_DONE  (CLR_DONE),
`ifdef BKY_PARITY_EN
    .DIN_PAR   (DIN_PAR),
    .PAR_ERR   (PAR_ERR),
`endif
    .SCLK      (SCLK),
    .SDATA     (SDATA),
    .SHCK_ENA  (SHCK_ENA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .EMPTY     (EMPTY),
    .FULL      (FULL),
    .OVF       (OVF),
    .FILL      (FILL),
    .STATE     (STATE)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  typedef struct {
    logic [WORD_W-1:0] w;
    logic              bad;
  } ent_t;

  ent_t q[$];
  logic done_m, ovf_m, perr_m;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  task automatic drive_word(input logic [WORD_W-1:0] w, input logic bad);
    CAPTURE = 1'b1;
    DIN     = w;
`ifdef BKY_PARITY_EN
    DIN_PAR = (^w) ^ bad;
`endif
  endtask

  // Push while idle: the model drops the word and flags overflow when the FIFO is full.
  task automatic push_word(input logic [WORD_W-1:0] w, input logic bad);
    ent_t e;
    drive_word(w, bad);
    tick();
    CAPTURE = 1'b0;
    e.w = w;
    e.bad = bad;
    if (q.size() < DEPTH) q.push_back(e);
    else ovf_m = 1'b1;
  endtask

  task automatic clear_done();
    CLR_DONE = 1'b1;
    tick();
    CLR_DONE = 1'b0;
    done_m = 1'b0;
    ovf_m  = 1'b0;
    perr_m = 1'b0;
  endtask

  // Runs a whole load from START to the return to IDLE, checking every cycle of the line.
  task automatic do_load(input logic [NCHAN-1:0] mask, input int mid_j, input logic cap_at_load,
                         input logic clr_at_fin);
    int   nwords;
    int   rises;
    logic prev;
    logic bitv, sclk_e;
    ent_t e, ne;
    nwords = 0;
    rises  = 0;
    START = 1'b1;
    CHAN_MASK = mask;
    tick();
    START = 1'b0;
    CHAN_MASK = NCHAN'($urandom);
    do begin
      check("load_state", 32'(STATE), 32'd1);
      check("load_lines", {SHCK_ENA, SCLK, SDATA}, 32'd0);
      e = q.pop_front();
      nwords++;
      if (e.bad) perr_m = 1'b1;
      if (cap_at_load && nwords == 1) begin
        ne.w = WORD_W'($urandom);
        ne.bad = 1'b0;
        drive_word(ne.w, 1'b0);
        q.push_back(ne);
      end
      tick();
      CAPTURE = 1'b0;
      check("ovf", 32'(OVF), 32'(ovf_m));
`ifdef BKY_PARITY_EN
      check("par_err", 32'(PAR_ERR), 32'(perr_m));
`endif
      prev = 1'b0;
      for (int j = 0; j < BIT_CYC * WORD_W; j++) begin
        bitv   = e.w[j / BIT_CYC];
        sclk_e = (j % BIT_CYC) >= HALF_DIV;
        check("shift_lines", {SHCK_ENA, SCLK, SDATA}, {1'b1, sclk_e, (bitv ? mask : 6'd0)});
        if (SCLK && !prev) rises++;
        prev = SCLK;
        if (j == mid_j && nwords == 1) begin
          ne.w = WORD_W'($urandom);
          ne.bad = 1'b0;
          drive_word(ne.w, 1'b0);
          q.push_back(ne);
        end else begin
          CAPTURE = 1'b0;
        end
        tick();
      end
      CAPTURE = 1'b0;
      check("next_state", 32'(STATE), 32'd3);
      tick();
    end while (q.size() != 0 && nwords < DEPTH + 2);
    check("fin_state", 32'(STATE), 32'd4);
    check("fin_lines", {SHCK_ENA, SCLK, SDATA}, 32'd0);
    check("fin_done_old", 32'(DONE), 32'(done_m));
    CLR_DONE = clr_at_fin;
    tick();
    CLR_DONE = 1'b0;
    if (clr_at_fin) begin
      done_m = 1'b0;
      ovf_m  = 1'b0;
      perr_m = 1'b0;
    end else begin
      done_m = 1'b1;
    end
    check("done", 32'(DONE), 32'(done_m));
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_state", 32'(STATE), 32'd0);
    check("fill_end", 32'(FILL), 32'(q.size()));
    check("sclk_rises", 32'(rises), 32'(16 * nwords));
  endtask

  initial begin
    int n;
    int mid;
    RST_N = 1'b0; CAPTURE = 1'b0; START = 1'b0; FLUSH = 1'b0; CLR_DONE = 1'b0;
    DIN = '0; CHAN_MASK = '0;
`ifdef BKY_PARITY_EN
    DIN_PAR = 1'b0;
`endif
    done_m = 1'b0; ovf_m = 1'b0; perr_m = 1'b0;
    tick();
    tick();
    check("rst_flags", {EMPTY, FULL, BUSY, DONE, OVF, SHCK_ENA, SCLK}, 32'h40);
    check("rst_fill", 32'(FILL), 32'd0);
    check("rst_sdata", 32'(SDATA), 32'd0);
    check("rst_state", 32'(STATE), 32'd0);
    RST_N = 1'b1;
    tick();

    // Known pattern on chains 0 and 2; DONE lands 67 cycles after START is taken.
    push_word(16'hA5C3, 1'b0);
    check("fill_one", 32'(FILL), 32'd1);
    do_load(6'b000101, -1, 1'b0, 1'b0);

    // Three words queued plus one captured mid-shift: four words back-to-back.
    clear_done();
    check("done_cleared", 32'(DONE), 32'd0);
    for (int i = 0; i < 3; i++) push_word(WORD_W'($urandom), 1'b0);
    do_load(NCHAN'($urandom), 17, 1'b0, 1'b0);

    // Fill to the brim, overflow once, then capture alongside the LOAD pop.
    clear_done();
    for (int i = 0; i < DEPTH; i++) push_word(WORD_W'($urandom), 1'b0);
    check("full_flag", 32'(FULL), 32'd1);
    check("full_fill", 32'(FILL), 32'(DEPTH));
    push_word(16'hDEAD, 1'b0);
    check("ovf_set", 32'(OVF), 32'd1);
    check("ovf_fill", 32'(FILL), 32'(DEPTH));
    clear_done();
    check("ovf_clr", 32'(OVF), 32'd0);
    do_load(6'b111111, -1, 1'b1, 1'b0);

    // START on an empty FIFO does nothing; CLR_DONE at FIN wins over the set.
    clear_done();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("empty_start_busy", 32'(BUSY), 32'd0);
    tick();
    check("empty_start_done", {BUSY, DONE}, 32'd0);
    push_word(WORD_W'($urandom), 1'b0);
    do_load(6'b100001, -1, 1'b0, 1'b1);

    // FLUSH in idle empties the FIFO.
    for (int i = 0; i < 3; i++) push_word(WORD_W'($urandom), 1'b0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    q.delete();
    check("flush", {EMPTY, FILL}, 32'h10);

    // Reset in the middle of a word aborts everything.
    push_word(WORD_W'($urandom), 1'b0);
    push_word(WORD_W'($urandom), 1'b0);
    START = 1'b1;
    CHAN_MASK = 6'b111111;
    tick();
    START = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    q.delete();
    done_m = 1'b0; ovf_m = 1'b0; perr_m = 1'b0;
    check("rst_mid_lines", {SCLK, SDATA}, 32'd0);
    check("rst_mid_flags", {BUSY, EMPTY, DONE}, 32'h2);
    check("rst_mid_state", 32'(STATE), 32'd0);
    check("rst_mid_fill", 32'(FILL), 32'd0);
    tick();

`ifdef BKY_PARITY_EN
    // A bad parity bit is flagged at LOAD but the word still goes out.
    push_word(16'hA5C3, 1'b1);
    do_load(6'b010101, -1, 1'b0, 1'b0);
    check("par_err_held", 32'(PAR_ERR), 32'd1);
    clear_done();
    check("par_err_clr", 32'(PAR_ERR), 32'd0);
`endif

    // Random loads with random masks, sizes and occasional mid-shift captures.
    for (int it = 0; it < 6; it++) begin
      clear_done();
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
`ifdef BKY_PARITY_EN
        push_word(WORD_W'($urandom), 1'($urandom_range(0, 1)));
`else
        push_word(WORD_W'($urandom), 1'b0);
`endif
      end
      mid = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 59));
      do_load(NCHAN'($urandom), mid, 1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
